fc_stream_feeder: RTL and testbench

- Transmit side of the fully-connected layer's input stream.
- On start, reads the 2304-entry ternary activation buffer and the matching weight row from weight ROM, then emits one contiguous burst of (data, weight, valid) beats per output neuron.
- After each burst it waits for the FC result strobe before starting the next neuron. It repeats this for all N_OUT neurons, then signals done.
- Sits between the conv/pool activation buffer plus weight ROM and the FC accumulator.

---
 rtl/fc_pkg.sv | 19 +
 rtl/tern_sanitize.sv | 18 +
 rtl/fc_stream_feeder.sv | 148 ++++++++++++++
 tb/tb_fc_stream_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared ternary codes, layer sizes and FSM encoding for the FC input feeder
package fc_pkg;
    localparam logic [1:0] TERN_ZERO    = 2'b00;
    localparam logic [1:0] TERN_POS     = 2'b01;
    localparam logic [1:0] TERN_NEG     = 2'b11;
    localparam logic [1:0] TERN_ILLEGAL = 2'b10;

    localparam int FC_N_IN  = 2304;
    localparam int FC_N_OUT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_GAP,
        ST_WAIT_FC,
        ST_DONE
    } fc_state_t;
endpackage

// File: rtl/tern_sanitize.sv
// rtl/tern_sanitize.sv - maps the illegal ternary code to zero and flags it
module tern_sanitize
    import fc_pkg::*;
(
    input  logic [1:0] code,
    output logic [1:0] value,
    output logic       illegal
);
    always_comb begin
        value   = TERN_ZERO;
        illegal = 1'b0;
        case (code)
            TERN_ZERO, TERN_POS, TERN_NEG: value = code;
            TERN_ILLEGAL:                  illegal = 1'b1;
            default:                       illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/fc_stream_feeder.sv
// rtl/fc_stream_feeder.sv - streams activation/weight beats per neuron into the FC accumulator
module fc_stream_feeder
    import fc_pkg::*;
#(
    parameter int N_IN    = FC_N_IN,
    parameter int N_OUT   = FC_N_OUT,
    parameter int ACT_AW  = 12,
    parameter int W_AW    = 15,
    parameter int MIN_GAP = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    output logic [ACT_AW-1:0] o_act_addr,
    output logic              o_act_rd,
    input  logic [1:0]        i_act_rdata,
    output logic [W_AW-1:0]   o_w_addr,
    output logic              o_w_rd,
    input  logic [1:0]        i_w_rdata,
    output logic [1:0]        o_data,
    output logic [1:0]        o_weight,
    output logic              o_valid,
    input  logic              i_fc_done,
    output logic [3:0]        o_neuron,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_code_err
);
    localparam logic [ACT_AW-1:0] ACT_LAST    = ACT_AW'(N_IN - 1);
    localparam logic [3:0]        NEURON_LAST = 4'(N_OUT - 1);
    localparam logic [1:0]        DRAIN_LAST  = 2'd1;
    localparam logic [1:0]        GAP_LAST    = 2'(MIN_GAP - 1);

    fc_state_t  state;
    logic [1:0] phase_cnt;
    logic       rd_q;
    logic [1:0] act_clean;
    logic [1:0] w_clean;
    logic       act_bad;
    logic       w_bad;

    tern_sanitize u_act_sanitize (
        .code    (i_act_rdata),
        .value   (act_clean),
        .illegal (act_bad)
    );

    tern_sanitize u_w_sanitize (
        .code    (i_w_rdata),
        .value   (w_clean),
        .illegal (w_bad)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            rd_q       <= 1'b0;
            o_act_addr <= '0;
            o_act_rd   <= 1'b0;
            o_w_addr   <= '0;
            o_w_rd     <= 1'b0;
            o_data     <= '0;
            o_weight   <= '0;
            o_valid    <= 1'b0;
            o_neuron   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_code_err <= 1'b0;
        end else begin
            // Two-stage output pipe: read issued, RAM data returns, beat registered
            rd_q    <= o_act_rd;
            o_valid <= rd_q;
            o_done  <= 1'b0;
            if (rd_q) begin
                o_data   <= act_clean;
                o_weight <= w_clean;
                if (act_bad || w_bad) begin
                    o_code_err <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_READ;
                        o_act_rd   <= 1'b1;
                        o_w_rd     <= 1'b1;
                        o_act_addr <= '0;
                        o_w_addr   <= '0;
                        o_neuron   <= '0;
                        o_code_err <= 1'b0;
                        o_busy     <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (o_act_addr == ACT_LAST) begin
                        state     <= ST_DRAIN;
                        o_act_rd  <= 1'b0;
                        o_w_rd    <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        o_act_addr <= o_act_addr + 1'b1;
                        o_w_addr   <= o_w_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (phase_cnt == DRAIN_LAST) begin
                        state     <= ST_GAP;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        state <= ST_WAIT_FC;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_WAIT_FC: begin
                    if (i_fc_done) begin
                        if (o_neuron == NEURON_LAST) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            // Weight address keeps counting across neurons: row n starts at n*N_IN
                            state      <= ST_READ;
                            o_neuron   <= o_neuron + 1'b1;
                            o_act_addr <= '0;
                            o_w_addr   <= o_w_addr + 1'b1;
                            o_act_rd   <= 1'b1;
                            o_w_rd     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fc_stream_feeder.sv
// tb/tb_fc_stream_feeder.sv - self-checking bench for fc_stream_feeder
module tb_fc_stream_feeder;
    localparam int N_IN   = 2304;
    localparam int N_OUT  = 10;
    localparam int ACT_AW = 12;
    localparam int W_AW   = 15;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              i_start = 1'b0;
    logic              i_fc_done = 1'b0;
    logic [ACT_AW-1:0] o_act_addr;
    logic              o_act_rd;
    logic [1:0]        i_act_rdata = 2'b00;
    logic [W_AW-1:0]   o_w_addr;
    logic              o_w_rd;
    logic [1:0]        i_w_rdata = 2'b00;
    logic [1:0]        o_data;
    logic [1:0]        o_weight;
    logic              o_valid;
    logic [3:0]        o_neuron;
    logic              o_busy;
    logic              o_done;
    logic              o_code_err;
    logic [40:0]       all_out;

    logic [1:0] act_mem [0:4095];
    logic [1:0] w_mem   [0:32767];

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int last_run_reads = 0;
    int last_w = 0;
    int addr_bad = 0;
    int done_cnt = 0;

    assign all_out = {o_act_addr, o_act_rd, o_w_addr, o_w_rd, o_data, o_weight,
                      o_valid, o_neuron, o_busy, o_done, o_code_err};

    always #5 clk = ~clk;

    fc_stream_feeder dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_start     (i_start),
        .o_act_addr  (o_act_addr),
        .o_act_rd    (o_act_rd),
        .i_act_rdata (i_act_rdata),
        .o_w_addr    (o_w_addr),
        .o_w_rd      (o_w_rd),
        .i_w_rdata   (i_w_rdata),
        .o_data      (o_data),
        .o_weight    (o_weight),
        .o_valid     (o_valid),
        .i_fc_done   (i_fc_done),
        .o_neuron    (o_neuron),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_code_err  (o_code_err)
    );

    // Synchronous-read memories: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (o_act_rd === 1'b1) i_act_rdata <= act_mem[o_act_addr];
        if (o_w_rd === 1'b1)   i_w_rdata   <= w_mem[o_w_addr];
    end

    // Within a run the k-th read must address weight k and activation k mod N_IN
    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt <= done_cnt + 1;
        if (o_act_rd !== o_w_rd) addr_bad <= addr_bad + 1;
        if (o_busy !== 1'b1) begin
            rd_cnt <= 0;
        end else if (o_act_rd === 1'b1) begin
            if (int'(o_w_addr) != rd_cnt || int'(o_act_addr) != rd_cnt % N_IN)
                addr_bad <= addr_bad + 1;
            rd_cnt         <= rd_cnt + 1;
            last_run_reads <= rd_cnt + 1;
            last_w         <= int'(o_w_addr);
        end
    end

    function automatic logic [1:0] tern_fwd(input logic [1:0] c);
        int v;
        case (c)
            2'b01:   v = 1;
            2'b11:   v = -1;
            default: v = 0;
        endcase
        return (v == 1) ? 2'b01 : (v == -1) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [1:0] rand_tern();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic do_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pulse_fc(input int delay);
        repeat (delay) @(negedge clk);
        i_fc_done = 1'b1;
        @(negedge clk);
        i_fc_done = 1'b0;
    endtask

    task automatic collect_burst(input int n, input int poke_at, input int probe_at, input int rst_at,
                                 output int len, output int bad, output int timeout,
                                 output logic [2:0] probe);
        int waitc;
        len = 0; bad = 0; timeout = 0; probe = '0; waitc = 0;
        while (o_valid !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (o_valid !== 1'b1) begin
            timeout = 1;
            return;
        end
        while (o_valid === 1'b1 && len <= N_IN) begin
            if (len >= N_IN || o_neuron !== 4'(n) ||
                o_data !== tern_fwd(act_mem[len]) ||
                o_weight !== tern_fwd(w_mem[n * N_IN + len]))
                bad++;
            if (len == probe_at - 1) probe[0] = o_code_err;
            if (len == probe_at) begin
                probe[1] = o_code_err;
                probe[2] = (o_data === 2'b00);
            end
            if (len == rst_at) begin
                resetn = 1'b0;
                #1;
                return;
            end
            if (len == poke_at) begin
                i_start   = 1'b1;
                i_fc_done = 1'b1;
            end
            if (len == poke_at + 1) begin
                i_start   = 1'b0;
                i_fc_done = 1'b0;
            end
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_act_rd !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b valid=%b rd=%b expected 0 0 0", o_busy, o_valid, o_act_rd);
        end
    endtask

    task automatic test_all_ones();
        int len, bad, tmo, lat, d0;
        logic [2:0] probe;
        for (int i = 0; i < 4096; i++) act_mem[i] = 2'b01;
        for (int i = 0; i < 32768; i++) w_mem[i] = 2'b01;
        d0 = done_cnt;
        do_start();
        tests++;
        if (o_busy !== 1'b1 || o_act_rd !== 1'b1) begin
            fails++;
            $display("FAIL ones_busy_rise: busy=%b rd=%b expected 1 1", o_busy, o_act_rd);
        end
        lat = 0;
        while (o_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != 2) begin
            fails++;
            $display("FAIL ones_first_beat_latency: got %0d expected 2", lat);
        end
        for (int n = 0; n < N_OUT; n++) begin
            collect_burst(n, -1, -1, -1, len, bad, tmo, probe);
            tests++;
            if (len != N_IN || bad != 0 || tmo != 0) begin
                fails++;
                $display("FAIL ones_burst%0d: len=%0d bad=%0d timeout=%0d expected len=%0d bad=0 timeout=0",
                         n, len, bad, tmo, N_IN);
            end
            pulse_fc(4);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL ones_done_pulses: got %0d expected 1", done_cnt - d0);
        end
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_neuron !== 4'd9) begin
            fails++;
            $display("FAIL ones_end_state: busy=%b valid=%b neuron=%0d expected 0 0 9", o_busy, o_valid, o_neuron);
        end
        tests++;
        if (last_run_reads != N_IN * N_OUT || last_w != N_IN * N_OUT - 1 || addr_bad != 0) begin
            fails++;
            $display("FAIL ones_addressing: reads=%0d last_w=%0d addr_bad=%0d expected %0d %0d 0",
                     last_run_reads, last_w, addr_bad, N_IN * N_OUT, N_IN * N_OUT - 1);
        end
    endtask

    task automatic test_random_run();
        int len, bad, tmo, lat, viol;
        logic [2:0] probe;
        for (int i = 0; i < N_IN; i++) act_mem[i] = rand_tern();
        act_mem[100] = 2'b10;
        for (int i = 0; i < N_IN * N_OUT; i++) w_mem[i] = rand_tern();
        do_start();
        for (int n = 0; n < N_OUT; n++) begin
            collect_burst(n, (n == 1) ? 500 : -1, (n == 0) ? 100 : -1, -1, len, bad, tmo, probe);
            tests++;
            if (len != N_IN || bad != 0 || tmo != 0) begin
                fails++;
                $display("FAIL rand_burst%0d: len=%0d bad=%0d timeout=%0d expected len=%0d bad=0 timeout=0",
                         n, len, bad, tmo, N_IN);
            end
            if (n == 0) begin
                tests++;
                if (probe !== 3'b110) begin
                    fails++;
                    $display("FAIL rand_illegal_code: {data00,err@100,err@99}=%b expected 110", probe);
                end
            end
            if (n == 1) begin
                tests++;
                if (o_neuron !== 4'd1 || o_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL rand_ignore_mid_burst: neuron=%0d busy=%b expected 1 1", o_neuron, o_busy);
                end
            end
            if (n == 2) begin
                viol = 0;
                repeat (500) begin
                    @(negedge clk);
                    if (o_valid !== 1'b0 || o_neuron !== 4'd2 || o_busy !== 1'b1) viol++;
                end
                tests++;
                if (viol != 0) begin
                    fails++;
                    $display("FAIL rand_wait_fc_hold: violations=%0d expected 0", viol);
                end
                i_fc_done = 1'b1;
                @(negedge clk);
                i_fc_done = 1'b0;
                lat = 0;
                while (o_valid !== 1'b1 && lat < 10) begin
                    @(negedge clk);
                    lat++;
                end
                tests++;
                if (lat != 2) begin
                    fails++;
                    $display("FAIL rand_resume_latency: got %0d expected 2", lat);
                end
            end else begin
                pulse_fc(4);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (o_code_err !== 1'b1 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_err_sticky: err=%b busy=%b expected 1 0", o_code_err, o_busy);
        end
        tests++;
        if (last_run_reads != N_IN * N_OUT || addr_bad != 0) begin
            fails++;
            $display("FAIL rand_addressing: reads=%0d addr_bad=%0d expected %0d 0",
                     last_run_reads, addr_bad, N_IN * N_OUT);
        end
    endtask

    task automatic test_reset_mid_burst();
        int len, bad, tmo, ok;
        logic [2:0] probe;
        do_start();
        tests++;
        if (o_code_err !== 1'b0 || o_act_addr !== '0 || o_w_addr !== '0) begin
            fails++;
            $display("FAIL start_clears: err=%b act=%0d w=%0d expected 0 0 0", o_code_err, o_act_addr, o_w_addr);
        end
        ok = 0;
        for (int n = 0; n < 3; n++) begin
            collect_burst(n, -1, -1, -1, len, bad, tmo, probe);
            if (len == N_IN && bad == 0 && tmo == 0) ok++;
            pulse_fc(4);
        end
        tests++;
        if (ok != 3) begin
            fails++;
            $display("FAIL pre_reset_bursts: good=%0d expected 3", ok);
        end
        collect_burst(3, -1, -1, 1000, len, bad, tmo, probe);
        tests++;
        if (len != 1000 || bad != 0 || tmo != 0) begin
            fails++;
            $display("FAIL reset_point: len=%0d bad=%0d timeout=%0d expected 1000 0 0", len, bad, tmo);
        end
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: got %h expected 0", all_out);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_neuron !== 4'd0 || o_act_rd !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_abort: busy=%b valid=%b neuron=%0d rd=%b expected 0 0 0 0",
                     o_busy, o_valid, o_neuron, o_act_rd);
        end
    endtask

    task automatic test_restart();
        int len, bad, tmo, ab0;
        logic [2:0] probe;
        ab0 = addr_bad;
        do_start();
        tests++;
        if (o_neuron !== 4'd0 || o_act_addr !== '0 || o_w_addr !== '0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_origin: neuron=%0d act=%0d w=%0d busy=%b expected 0 0 0 1",
                     o_neuron, o_act_addr, o_w_addr, o_busy);
        end
        for (int n = 0; n < 2; n++) begin
            collect_burst(n, -1, -1, -1, len, bad, tmo, probe);
            tests++;
            if (len != N_IN || bad != 0 || tmo != 0) begin
                fails++;
                $display("FAIL restart_burst%0d: len=%0d bad=%0d timeout=%0d expected len=%0d bad=0 timeout=0",
                         n, len, bad, tmo, N_IN);
            end
            pulse_fc(4);
        end
        tests++;
        if (addr_bad != ab0 || last_run_reads != 2 * N_IN) begin
            fails++;
            $display("FAIL restart_addressing: addr_bad=%0d reads=%0d expected %0d %0d",
                     addr_bad, last_run_reads, ab0, 2 * N_IN);
        end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_random_run();
        test_reset_mid_burst();
        test_restart();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
